// File: rtl/decode_queue.sv
// decode_queue: instruction decoder followed by a DEPTH-entry FIFO of decoded records.
// Each accepted instruction is fully decoded at enqueue time; the head record is
// presented to the execute stage over a valid/ready handshake.
// Ports:
//   clk, rstn (sync, active-low), flush         - clock, reset, discard all entries
//   in_valid/in_ready, in_instruction, in_pc    - fetch-side handshake and payload
//   out_valid/out_ready                         - execute-side handshake
//   out_pc, out_rs1/rs2/rd_address, out_imm     - head record operands
//   out_alu_operator, out_*_enable, out_mem_*   - head record control fields
//   out_branch, out_jump, out_stdin, out_stdout - head record control-flow / IO flags
//   out_illegal                                 - head instruction is illegal
//   occupancy                                   - number of valid entries
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instruction,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [4:0]                   out_rs1_address,
  output logic [4:0]                   out_rs2_address,
  output logic [4:0]                   out_rd_address,
  output logic [XLEN-1:0]              out_imm,
  output logic [3:0]                   out_alu_operator,
  output logic                         out_reg_write_enable,
  output logic                         out_ram_write_enable,
  output logic                         out_ram_read_enable,
  output logic [1:0]                   out_mem_width,
  output logic                         out_mem_unsigned,
  output logic                         out_branch,
  output logic                         out_jump,
  output logic                         out_stdin,
  output logic                         out_stdout,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IO     = 7'b0001011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic            regw;
    logic            ramw;
    logic            ramr;
    logic [1:0]      memw;
    logic            memu;
    logic            branch;
    logic            jump;
    logic            stdin;
    logic            stdout;
    logic            illegal;
  } rec_t;

  rec_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  rec_t            w_dec;
  rec_t            w_head;
  logic            w_ok;
  logic            w_push;
  logic            w_pop;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_sh;

  assign w_op = in_instruction[6:0];
  assign w_f3 = in_instruction[14:12];
  assign w_f7 = in_instruction[31:25];

  // Immediates are built as sign bit replicated above the remaining field bits,
  // which keeps the expressions valid for both XLEN=32 and XLEN=64.
  assign w_imm_i  = {{(XLEN-11){in_instruction[31]}}, in_instruction[30:20]};
  assign w_imm_s  = {{(XLEN-11){in_instruction[31]}}, in_instruction[30:25], in_instruction[11:7]};
  assign w_imm_b  = {{(XLEN-12){in_instruction[31]}}, in_instruction[7], in_instruction[30:25],
                     in_instruction[11:8], 1'b0};
  assign w_imm_j  = {{(XLEN-20){in_instruction[31]}}, in_instruction[19:12], in_instruction[20],
                     in_instruction[30:21], 1'b0};
  assign w_imm_u  = {{(XLEN-31){in_instruction[31]}}, in_instruction[30:12], 12'h000};
  assign w_imm_sh = {{(XLEN-5){1'b0}}, in_instruction[24:20]};

  // Combinational decode of the offered instruction; unrecognised encodings collapse to all-zero plus illegal.
  always_comb begin
    w_dec = '0;
    w_ok  = 1'b1;
    case (w_op)
      OP_R: begin
        w_dec.regw = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_dec.alu = ALU_ADD;
            3'b001:  w_dec.alu = ALU_SLL;
            3'b010:  w_dec.alu = ALU_SLT;
            3'b011:  w_dec.alu = ALU_SLTU;
            3'b100:  w_dec.alu = ALU_XOR;
            3'b101:  w_dec.alu = ALU_SRL;
            3'b110:  w_dec.alu = ALU_OR;
            default: w_dec.alu = ALU_AND;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          case (w_f3)
            3'b000:  w_dec.alu = ALU_SUB;
            3'b101:  w_dec.alu = ALU_SRA;
            default: w_ok = 1'b0;
          endcase
        end else begin
          w_ok = 1'b0;
        end
      end
      OP_IALU: begin
        w_dec.regw = 1'b1;
        w_dec.imm  = w_imm_i;
        case (w_f3)
          3'b000: w_dec.alu = ALU_ADD;
          3'b010: w_dec.alu = ALU_SLT;
          3'b011: w_dec.alu = ALU_SLTU;
          3'b100: w_dec.alu = ALU_XOR;
          3'b110: w_dec.alu = ALU_OR;
          3'b111: w_dec.alu = ALU_AND;
          3'b001: begin
            w_dec.alu = ALU_SLL;
            w_dec.imm = w_imm_sh;
            w_ok      = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_dec.alu = (w_f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            w_dec.imm = w_imm_sh;
            w_ok      = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          default: w_ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        w_dec.ramr = 1'b1;
        w_dec.regw = 1'b1;
        w_dec.memw = w_f3[1:0];
        w_dec.memu = w_f3[2];
        w_dec.imm  = w_imm_i;
        w_ok       = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      end
      OP_STORE: begin
        w_dec.ramw = 1'b1;
        w_dec.memw = w_f3[1:0];
        w_dec.imm  = w_imm_s;
        w_ok       = (w_f3 <= 3'b010);
      end
      OP_BRANCH: begin
        w_dec.branch = 1'b1;
        w_dec.imm    = w_imm_b;
        case (w_f3)
          3'b000, 3'b001: w_dec.alu = ALU_SUB;
          3'b100, 3'b101: w_dec.alu = ALU_SLT;
          3'b110, 3'b111: w_dec.alu = ALU_SLTU;
          default:        w_ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        w_dec.jump = 1'b1;
        w_dec.regw = 1'b1;
        w_dec.imm  = w_imm_j;
      end
      OP_JALR: begin
        w_dec.jump = 1'b1;
        w_dec.regw = 1'b1;
        w_dec.imm  = w_imm_i;
        w_ok       = (w_f3 == 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        w_dec.regw = 1'b1;
        w_dec.imm  = w_imm_u;
      end
      OP_IO: begin
        case (w_f3)
          3'b000: begin
            w_dec.stdin = 1'b1;
            w_dec.regw  = 1'b1;
          end
          3'b001:  w_dec.stdout = 1'b1;
          default: w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
    if (w_ok) begin
      w_dec.rs1 = in_instruction[19:15];
      w_dec.rs2 = in_instruction[24:20];
      w_dec.rd  = in_instruction[11:7];
    end else begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.pc = in_pc;
  end

  // in_ready depends only on state and reset, never on out_ready.
  assign in_ready  = rstn && (r_count < CNT_DEPTH);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign occupancy = r_count;

  // FIFO state: reset clears storage, flush clears only pointers and count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head               = r_mem[r_rd_ptr];
  assign out_pc               = w_head.pc;
  assign out_rs1_address      = w_head.rs1;
  assign out_rs2_address      = w_head.rs2;
  assign out_rd_address       = w_head.rd;
  assign out_imm              = w_head.imm;
  assign out_alu_operator     = w_head.alu;
  assign out_reg_write_enable = w_head.regw;
  assign out_ram_write_enable = w_head.ramw;
  assign out_ram_read_enable  = w_head.ramr;
  assign out_mem_width        = w_head.memw;
  assign out_mem_unsigned     = w_head.memu;
  assign out_branch           = w_head.branch;
  assign out_jump             = w_head.jump;
  assign out_stdin            = w_head.stdin;
  assign out_stdout           = w_head.stdout;
  assign out_illegal          = w_head.illegal;

endmodule
